// File: rtl/kb_scr_term_if.sv
// kb_scr_term_if: key source, device-driver link and screen sink signals of the terminal endpoint.
// The slave modport is the endpoint's view; master is the surrounding system's view.
interface kb_scr_term_if;
    logic [7:0] key_data;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] dev_data_o;
    logic [1:0] dev_ctrl_o;
    logic [7:0] dev_data_i;
    logic [1:0] dev_ctrl_i;
    logic [7:0] scr_data;
    logic       scr_valid;
    logic       scr_ready;
    modport slave (
        input  key_data, key_valid, dev_data_i, dev_ctrl_i, scr_ready,
        output key_ready, dev_data_o, dev_ctrl_o, scr_data, scr_valid
    );
    modport master (
        output key_data, key_valid, dev_data_i, dev_ctrl_i, scr_ready,
        input  key_ready, dev_data_o, dev_ctrl_o, scr_data, scr_valid
    );
endinterface

// File: rtl/kb_scr_term.sv
// kb_scr_term: terminal endpoint of the keyboard/screen link; feeds buffered keystrokes to the
// driver's write port and buffers de-inverted screen bytes from its read port for a display sink.
module kb_scr_term_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [7:0]              i_data,
    input  logic                    i_pop,
    output logic [7:0]              o_data,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;
    assign w_push  = i_push & (r_cnt != FULL);
    assign w_pop   = i_pop & (r_cnt != '0);
    assign o_data  = (r_cnt == '0) ? 8'h00 : r_mem[r_rd];
    assign o_count = r_cnt;
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

module kb_scr_term #(
    parameter int KB_DEPTH    = 8,
    parameter int SCR_DEPTH   = 8,
    parameter int ACK_TIMEOUT = 255,
    parameter int GAP_CYC     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    kb_scr_term_if.slave  bus,
    output logic          kb_timeout,
    output logic [3:0]    kb_level
);
    localparam int KW = $clog2(KB_DEPTH);
    localparam int SW = $clog2(SCR_DEPTH);
    localparam logic [KW:0] KB_FULL  = KB_DEPTH[KW:0];
    localparam logic [SW:0] SCR_FULL = SCR_DEPTH[SW:0];
    localparam logic [7:0]  TO_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

    typedef enum logic [1:0] {K_IDLE, K_DRIVE, K_WAIT, K_GAP} k_state_t;
    typedef enum logic {S_IDLE, S_ACK} s_state_t;

    k_state_t    r_kst, w_kst_nxt;
    s_state_t    r_sst, w_sst_nxt;
    logic        r_we, w_we_nxt;
    logic [7:0]  r_kdat, w_kdat_nxt;
    logic [7:0]  r_tcnt, w_tcnt_nxt;
    logic [7:0]  r_gcnt, w_gcnt_nxt;
    logic        r_timeout;
    logic        r_rok, w_rok_nxt;
    logic        w_to_set;
    logic        w_kb_push, w_kb_pop;
    logic        w_scr_push, w_scr_pop;
    logic        w_kb_full, w_kb_empty, w_scr_full, w_scr_empty;
    logic [7:0]  w_kb_head, w_scr_head;
    logic [KW:0] w_kb_cnt;
    logic [SW:0] w_scr_cnt;
    logic        w_write_ok_n;
    logic        w_read_en_n;

    assign w_read_en_n  = bus.dev_ctrl_i[1];
    assign w_write_ok_n = bus.dev_ctrl_i[0];
    assign w_kb_full    = w_kb_cnt == KB_FULL;
    assign w_kb_empty   = w_kb_cnt == '0;
    assign w_scr_full   = w_scr_cnt == SCR_FULL;
    assign w_scr_empty  = w_scr_cnt == '0;
    // key_ready is forced low while reset is asserted, not just after the first reset edge
    assign bus.key_ready = rst_n & ~w_kb_full;
    assign w_kb_push     = bus.key_valid & bus.key_ready;
    assign w_scr_pop     = ~w_scr_empty & bus.scr_ready;
    assign bus.dev_data_o = r_kdat;
    assign bus.dev_ctrl_o = {r_we, r_rok};
    assign bus.scr_data   = w_scr_head;
    assign bus.scr_valid  = ~w_scr_empty;
    assign kb_timeout     = r_timeout;
    assign kb_level       = (32'(w_kb_cnt) > 32'd15) ? 4'd15 : 4'(w_kb_cnt);

    kb_scr_term_fifo #(.DEPTH(KB_DEPTH)) u_kb_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_kb_push),
        .i_data  (bus.key_data),
        .i_pop   (w_kb_pop),
        .o_data  (w_kb_head),
        .o_count (w_kb_cnt)
    );

    kb_scr_term_fifo #(.DEPTH(SCR_DEPTH)) u_scr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_scr_push),
        .i_data  (~bus.dev_data_i),
        .i_pop   (w_scr_pop),
        .o_data  (w_scr_head),
        .o_count (w_scr_cnt)
    );

    // The head stays in the FIFO until the driver acks or the wait times out.
    always_comb begin
        w_kst_nxt  = r_kst;
        w_we_nxt   = r_we;
        w_kdat_nxt = r_kdat;
        w_tcnt_nxt = r_tcnt;
        w_gcnt_nxt = r_gcnt;
        w_kb_pop   = 1'b0;
        w_to_set   = 1'b0;
        case (r_kst)
            K_IDLE: begin
                if (!w_kb_empty) begin
                    w_kst_nxt  = K_DRIVE;
                    w_kdat_nxt = w_kb_head;
                end
            end
            K_DRIVE: begin
                w_we_nxt   = 1'b1;
                w_tcnt_nxt = 8'd0;
                w_kst_nxt  = K_WAIT;
            end
            K_WAIT: begin
                if (!w_write_ok_n || r_tcnt == TO_LAST) begin
                    w_kb_pop   = 1'b1;
                    w_to_set   = w_write_ok_n;
                    w_we_nxt   = 1'b0;
                    w_gcnt_nxt = 8'd0;
                    w_kst_nxt  = K_GAP;
                end else begin
                    w_tcnt_nxt = r_tcnt + 8'd1;
                end
            end
            K_GAP: begin
                w_kst_nxt  = (r_gcnt == GAP_LAST) ? K_IDLE : K_GAP;
                w_gcnt_nxt = r_gcnt + 8'd1;
            end
            default: w_kst_nxt = K_IDLE;
        endcase
    end

    always_comb begin
        w_sst_nxt  = r_sst;
        w_rok_nxt  = r_rok;
        w_scr_push = 1'b0;
        case (r_sst)
            S_IDLE: begin
                if (!w_read_en_n && !w_scr_full) begin
                    w_scr_push = 1'b1;
                    w_rok_nxt  = 1'b1;
                    w_sst_nxt  = S_ACK;
                end
            end
            S_ACK: begin
                if (w_read_en_n) begin
                    w_rok_nxt = 1'b0;
                    w_sst_nxt = S_IDLE;
                end
            end
            default: w_sst_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kst     <= K_IDLE;
            r_we      <= 1'b0;
            r_kdat    <= 8'h00;
            r_tcnt    <= 8'd0;
            r_gcnt    <= 8'd0;
            r_timeout <= 1'b0;
            r_sst     <= S_IDLE;
            r_rok     <= 1'b0;
        end else begin
            r_kst     <= w_kst_nxt;
            r_we      <= w_we_nxt;
            r_kdat    <= w_kdat_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_gcnt    <= w_gcnt_nxt;
            r_timeout <= r_timeout | w_to_set;
            r_sst     <= w_sst_nxt;
            r_rok     <= w_rok_nxt;
        end
    end
endmodule

// File: tb/tb_kb_scr_term.sv
// tb_kb_scr_term: directed checks of keystroke delivery, ack timeout and screen capture,
// with a behavioural driver on the keystroke port of the main instance.
module tb_kb_scr_term;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       write_ok = 1'b1;
    logic       read_en = 1'b1;
    logic       wok_b = 1'b1;
    logic       kb_timeout, kb_timeout_b;
    logic [3:0] kb_level, kb_level_b;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         hi;

    logic [7:0] keys [8] = '{8'h10, 8'h23, 8'h3C, 8'h4F, 8'h5A, 8'hA5, 8'hC3, 8'hFF};
    logic [7:0] sbus [9] = '{8'hBE, 8'h9A, 8'h00, 8'hFF, 8'h5A, 8'hC3, 8'h7E, 8'h81, 8'h0F};
    logic [7:0] sexp [9] = '{8'h41, 8'h65, 8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h81, 8'h7E, 8'hF0};

    kb_scr_term_if bus ();
    kb_scr_term_if bus_b ();
    assign bus.dev_ctrl_i   = {read_en, write_ok};
    assign bus_b.dev_ctrl_i = {1'b1, wok_b};

    kb_scr_term dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .kb_timeout (kb_timeout),
        .kb_level   (kb_level)
    );

    kb_scr_term #(.ACK_TIMEOUT(4)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_b),
        .kb_timeout (kb_timeout_b),
        .kb_level   (kb_level_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_key(input logic [7:0] b);
        bus.key_data  = b;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic offer(input logic [7:0] b);
        bus.dev_data_i = b;
        read_en = 1'b0;
        for (int i = 0; i < 10 && !bus.dev_ctrl_o[0]; i++) tick();
        check("t6_offer_ack", bus.dev_ctrl_o[0], 1);
        read_en = 1'b1;
        for (int i = 0; i < 10 && bus.dev_ctrl_o[0]; i++) tick();
    endtask

    // Driver model for the main instance: records each write_en rising edge, acks 2 cycles later.
    logic [7:0] rx_q [$];
    logic       ack_en = 1'b0;
    logic       prev_we = 1'b0;
    logic [7:0] cur = 8'h00;
    int         rises = 0, gap_bad = 0, stab_bad = 0, lo_cnt = 0, hi_cnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (bus.dev_ctrl_o[1]) begin
            if (!prev_we) begin
                if (rises > 0 && lo_cnt < 2) gap_bad++;
                rises++;
                rx_q.push_back(bus.dev_data_o);
                cur = bus.dev_data_o;
                hi_cnt = 0;
            end else begin
                hi_cnt++;
                if (bus.dev_data_o != cur) stab_bad++;
            end
            if (ack_en && hi_cnt >= 2) write_ok = 1'b0;
        end else begin
            lo_cnt = prev_we ? 1 : lo_cnt + 1;
            write_ok = 1'b1;
        end
        prev_we = bus.dev_ctrl_o[1];
    end

    initial begin
        bus.key_data     = 8'h00;
        bus.key_valid    = 1'b0;
        bus.dev_data_i   = 8'h00;
        bus.scr_ready    = 1'b0;
        bus_b.key_data   = 8'h00;
        bus_b.key_valid  = 1'b0;
        bus_b.dev_data_i = 8'h00;
        bus_b.scr_ready  = 1'b0;
        repeat (3) tick();
        check("rst_key_ready", bus.key_ready, 0);
        check("rst_dev_data", bus.dev_data_o, 8'h00);
        check("rst_dev_ctrl", bus.dev_ctrl_o, 2'b00);
        check("rst_scr_valid", bus.scr_valid, 0);
        check("rst_scr_data", bus.scr_data, 8'h00);
        check("rst_timeout", kb_timeout, 0);
        check("rst_level", kb_level, 0);
        rst_n = 1'b1;
        tick();
        check("rst_key_ready_after", bus.key_ready, 1);

        // reset while the keystroke sits in K_WAIT
        push_key(8'h55);
        for (int i = 0; i < 10 && !bus.dev_ctrl_o[1]; i++) tick();
        check("t1_we_up", bus.dev_ctrl_o[1], 1);
        tick();
        rst_n = 1'b0;
        tick();
        check("t1_ctrl_rst", bus.dev_ctrl_o, 2'b00);
        check("t1_level_rst", kb_level, 0);
        check("t1_ready_in_rst", bus.key_ready, 0);
        rst_n = 1'b1;
        tick();
        check("t1_ready_after", bus.key_ready, 1);
        check("t1_ctrl_after", bus.dev_ctrl_o, 2'b00);
        rx_q.delete();

        // single keystroke with prompt ack, 2-cycle latency to write_en
        ack_en = 1'b1;
        push_key(8'h41);
        check("t2_lat0", bus.dev_ctrl_o[1], 0);
        tick();
        check("t2_lat1", bus.dev_ctrl_o[1], 0);
        tick();
        check("t2_we_rise", bus.dev_ctrl_o[1], 1);
        check("t2_data", bus.dev_data_o, 8'h41);
        repeat (12) tick();
        check("t2_count", rx_q.size(), 1);
        check("t2_rx", rx_q[0], 8'h41);
        check("t2_we_low", bus.dev_ctrl_o[1], 0);
        check("t2_level", kb_level, 0);
        check("t2_timeout", kb_timeout, 0);

        // fill the keystroke FIFO while the driver withholds its ack
        rx_q.delete();
        ack_en = 1'b0;
        bus.key_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.key_data = keys[i];
            tick();
        end
        bus.key_valid = 1'b0;
        check("t3_level_full", kb_level, 8);
        check("t3_ready_full", bus.key_ready, 0);
        ack_en = 1'b1;
        for (int i = 0; i < 200 && rx_q.size() < 8; i++) tick();
        repeat (8) tick();
        check("t3_count", rx_q.size(), 8);
        for (int i = 0; i < 8; i++) check("t3_order", rx_q[i], keys[i]);
        check("t3_gap", gap_bad, 0);
        check("t3_stable", stab_bad, 0);
        check("t3_level_empty", kb_level, 0);
        check("t3_ready_again", bus.key_ready, 1);
        check("t3_timeout", kb_timeout, 0);

        // ack timeout on the ACK_TIMEOUT=4 instance, then a normally acked key
        bus_b.key_data  = 8'h11;
        bus_b.key_valid = 1'b1;
        tick();
        bus_b.key_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus_b.dev_ctrl_o[1]) hi++;
            else if (hi > 0) break;
            tick();
        end
        check("t4_wait_cycles", hi, 4);
        check("t4_timeout", kb_timeout_b, 1);
        check("t4_level", kb_level_b, 0);
        bus_b.key_data  = 8'h22;
        bus_b.key_valid = 1'b1;
        tick();
        bus_b.key_valid = 1'b0;
        for (int i = 0; i < 20 && !bus_b.dev_ctrl_o[1]; i++) tick();
        check("t4_next_we", bus_b.dev_ctrl_o[1], 1);
        check("t4_next_data", bus_b.dev_data_o, 8'h22);
        wok_b = 1'b0;
        hi = 0;
        for (int i = 0; i < 20 && bus_b.dev_ctrl_o[1]; i++) begin
            hi++;
            tick();
        end
        wok_b = 1'b1;
        check("t4_next_acked", hi, 1);
        check("t4_next_level", kb_level_b, 0);
        check("t4_sticky", kb_timeout_b, 1);

        // one screen byte, inverted on the bus
        bus.dev_data_i = 8'hBE;
        read_en = 1'b0;
        tick();
        check("t5_read_ok", bus.dev_ctrl_o[0], 1);
        check("t5_scr_valid", bus.scr_valid, 1);
        check("t5_scr_data", bus.scr_data, 8'h41);
        bus.dev_data_i = 8'h00;
        repeat (3) tick();
        check("t5_read_ok_held", bus.dev_ctrl_o[0], 1);
        read_en = 1'b1;
        tick();
        check("t5_read_ok_drop", bus.dev_ctrl_o[0], 0);
        bus.scr_ready = 1'b1;
        tick();
        bus.scr_ready = 1'b0;
        check("t5_single_entry", bus.scr_valid, 0);

        // screen FIFO backpressure: 9th byte waits for a pop
        for (int i = 0; i < 8; i++) offer(sbus[i]);
        bus.dev_data_i = sbus[8];
        read_en = 1'b0;
        repeat (4) tick();
        check("t6_full_no_ack", bus.dev_ctrl_o[0], 0);
        check("t6_head", bus.scr_data, sexp[0]);
        bus.scr_ready = 1'b1;
        tick();
        bus.scr_ready = 1'b0;
        check("t6_refused_on_pop", bus.dev_ctrl_o[0], 0);
        tick();
        check("t6_late_ack", bus.dev_ctrl_o[0], 1);
        read_en = 1'b1;
        tick();
        check("t6_ack_drop", bus.dev_ctrl_o[0], 0);
        for (int i = 1; i < 9; i++) begin
            check("t6_drain", bus.scr_data, sexp[i]);
            bus.scr_ready = 1'b1;
            tick();
            bus.scr_ready = 1'b0;
        end
        check("t6_empty", bus.scr_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule
